// File: rtl/mwadd_pkg.sv
// Shared constants and FSM state type for the multi-word add/subtract sequencer.
package mwadd_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mwadd_state_t;

endpackage

// File: rtl/parallel_adder.sv
// Combinational BYTE_W-bit ripple adder slice; the sequencer reuses it once per byte.
module parallel_adder
    import mwadd_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_seq.sv
// WORDS*8-bit add/subtract built from a single 8-bit adder, one byte per cycle, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module multiword_add_seq
    import mwadd_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W*WORDS-1:0] in_a,
    input  logic [BYTE_W*WORDS-1:0] in_b,
    input  logic                    in_cin,
    input  logic                    in_sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W*WORDS-1:0] out_sum,
    output logic                    out_cout,
    output logic                    busy
);

    localparam int unsigned W     = BYTE_W * WORDS;
    localparam int unsigned CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    mwadd_state_t     state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     result_q;
    logic             carry_q;
    logic             cout_q;
    logic [CNT_W-1:0] cnt_q;

    logic [BYTE_W-1:0] add_a;
    logic [BYTE_W-1:0] add_b;
    logic [BYTE_W-1:0] add_sum;
    logic              add_cout;
    logic              accept;

    assign add_a = a_q[cnt_q * BYTE_W +: BYTE_W];
    assign add_b = b_q[cnt_q * BYTE_W +: BYTE_W];

    parallel_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // A finished result can be retired and a new op captured in the same cycle.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = result_q;
    assign out_cout  = cout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1, so in_cin is replaced by the forced carry.
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub | in_cin;
            cnt_q   <= '0;
            state_q <= RUN;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    result_q[cnt_q * BYTE_W +: BYTE_W] <= add_sum;
                    carry_q <= add_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        cout_q  <= add_cout;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench: vector table plus hand-written backpressure, reset and isolation cases.
module tb_multiword_add_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W:0] sb[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[8];

    multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result handshake completes at the next posedge; compare against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h, expected no result", out_sum);
            end else begin
                logic [W:0] e;
                e = sb.pop_front();
                check("out_sum", 64'(out_sum), 64'(e[W-1:0]));
                check("out_cout", 64'(out_cout), 64'(e[W]));
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] exp_sum, input logic exp_cout);
        int guard;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
        sb.push_back({exp_cout, exp_sum});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat);
        int cycles;
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        check("latency", 64'(cycles), 64'(exp_lat));
        tick();
    endtask

    initial begin
        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0};
        vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);

        // Table-driven ops, each fully retired before the next.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].sum, vecs[i].cout);
            check("run_busy", 64'(busy), 64'd1);
            check("run_in_ready", 64'(in_ready), 64'd0);
            wait_result(WORDS);
        end

        // Backpressure in DONE, then same-cycle retire and accept.
        out_ready = 1'b0;
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        for (int i = 0; i < 3; i++) begin
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_sum", 64'(out_sum), 64'h30);
            check("hold_out_cout", 64'(out_cout), 64'd0);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_out_valid", 64'(out_valid), 64'd0);
        wait_result(WORDS);

        // Reset after byte 1 is written discards the op.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_sum", 64'(out_sum), 64'd0);
        send(32'h0000_0080, 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
        wait_result(WORDS);

        // Operand changes and in_valid pulses during RUN are ignored.
        send(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, 32'h0303_0303, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_a     = $urandom;
            in_b     = $urandom;
            in_cin   = 1'b1;
            in_sub   = 1'b1;
            in_valid = (i != 1);
            #1;
            check("iso_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        wait_result(1);

        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("end_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
